mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port E_CU_MDU_op, input, 4 bits: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-004 SHALL have port E_CU_MDU_start, input, 1 bit: asserted for exactly one cycle with op 1-4 to launch an operation.
REQ-005 SHALL have port E_ReadData_rs, input, 32 bits: operand A; also the source for mthi/mtlo.
REQ-006 SHALL have port E_ReadData_rt, input, 32 bits: operand B.
REQ-007 SHALL have port MDU_busy, output, 1 bit: registered; 1 while an operation is in flight.
REQ-008 SHALL have port MDU_stall, output, 1 bit: combinational stall request to the hazard unit.
REQ-009 SHALL have port MDU_out, output, 32 bits: combinational read data; HI for op 5, LO for op 6, 0 otherwise.
REQ-010 SHALL have port MDU_divzero, output, 1 bit: sticky divide-by-zero flag (see Configuration).

Function
REQ-011 SHALL implement three FSM states: IDLE, MULT, DIV; plus a 4-bit cycle counter and 32-bit HI, LO, HI_tmp and LO_tmp registers.
REQ-012 In IDLE, start=1 with op 1/2 SHALL go to MULT with counter=5; with op 3/4 SHALL go to DIV with counter=10.
REQ-013 SHALL compute the result at launch into HI_tmp/LO_tmp.
- mult: signed 64-bit product.
- multu: unsigned 64-bit product.
- div: LO=quotient, HI=remainder, signed, truncate toward zero, remainder takes the sign of the dividend.
- divu: unsigned quotient and remainder.
REQ-014 In MULT/DIV, the counter SHALL decrement each cycle.
REQ-015 On the edge where the counter goes 1->0, the block SHALL copy HI_tmp/LO_tmp to HI/LO and return to IDLE.
REQ-016 Result latency: HI/LO SHALL update 5 edges after the start edge for mult/multu and 10 edges after for div/divu.
REQ-017 MDU_busy SHALL be 1 exactly while the state is MULT or DIV.
REQ-018 MDU_stall SHALL be 1 when op is 1-8 and (MDU_busy=1 or start=1).
REQ-019 start=1 while busy SHALL be ignored: no relaunch, no state change.
REQ-020 mthi/mtlo while busy SHALL be ignored; in IDLE they SHALL write rs into HI/LO at the next edge.
REQ-021 mfhi/mflo SHALL return the architectural HI/LO, never HI_tmp/LO_tmp.
REQ-022 div/divu with rt=0 SHALL sequence normally for 10 cycles but commit nothing: HI and LO stay unchanged.
REQ-023 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 start=1 with op 0 or 5-15 SHALL be ignored.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, counter 0, HI=LO=HI_tmp=LO_tmp=0, MDU_busy=0, MDU_divzero=0.
REQ-026 Reset during MULT/DIV SHALL abort the operation with no commit to HI/LO.
REQ-027 The first start SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-028 Macro MDU_DIVZERO_FLAG_EN defined:
- MDU_divzero SHALL set at launch of div/divu with rt=0.
- It SHALL clear only on reset.
REQ-029 Macro MDU_DIVZERO_FLAG_EN undefined: MDU_divzero SHALL be constant 0; all other behaviour SHALL be identical.

Verification
REQ-030 mult, rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mflo returns 0xFFFFFFFA.
REQ-031 divu, rs=7, rt=2 -> busy for 10 cycles; then LO=3, HI=1. A second start at cycle 4 is ignored.
REQ-032 div, rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 mthi rs=0x1234 while busy -> HI unchanged. mthi rs=0x1234 in IDLE -> mfhi returns 0x1234 the next cycle.
REQ-034 div with rt=0 after mtlo 0x55 -> LO stays 0x55. MDU_divzero=1 with the macro defined, 0 without it.
REQ-035 reset=0 at cycle 3 of mult -> MDU_busy=0 immediately; HI=LO=0; no commit follows.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Optional sticky divide-by-zero flag enabled by defining MDU_DIVZERO_FLAG_EN.
module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_CU_MDU_op,
  input  logic        E_CU_MDU_start,
  input  logic [31:0] E_ReadData_rs,
  input  logic [31:0] E_ReadData_rt,
  output logic        MDU_busy,
  output logic        MDU_stall,
  output logic [31:0] MDU_out,
  output logic        MDU_divzero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q, hiTmp_q, loTmp_q;
  logic        commitEn_q;
  logic        busy_q;

  logic        isMult, isDiv, launch, rtZero;
  logic [31:0] hiTmp_d, loTmp_d;

  logic signed [63:0] sA64, sB64, prodS;
  logic        [63:0] prodU;
  logic signed [31:0] sA, sDivisor, quotS, remS;
  logic        [31:0] uDivisor, quotU, remU;

  assign isMult = (E_CU_MDU_op == OP_MULT) || (E_CU_MDU_op == OP_MULTU);
  assign isDiv  = (E_CU_MDU_op == OP_DIV)  || (E_CU_MDU_op == OP_DIVU);
  assign rtZero = (E_ReadData_rt == 32'd0);
  assign launch = (state_q == IDLE) && E_CU_MDU_start && (isMult || isDiv);

  // Divisor is forced to 1 for x/0 (never committed) and for INT_MIN/-1,
  // where dividing by 1 yields exactly the wrapped result LO=INT_MIN, HI=0.
  always_comb begin
    sA64     = {{32{E_ReadData_rs[31]}}, E_ReadData_rs};
    sB64     = {{32{E_ReadData_rt[31]}}, E_ReadData_rt};
    prodS    = sA64 * sB64;
    prodU    = {32'd0, E_ReadData_rs} * {32'd0, E_ReadData_rt};
    sA       = E_ReadData_rs;
    sDivisor = E_ReadData_rt;
    if (rtZero || (E_ReadData_rs == 32'h8000_0000 && E_ReadData_rt == 32'hFFFF_FFFF))
      sDivisor = 32'sd1;
    quotS    = sA / sDivisor;
    remS     = sA % sDivisor;
    uDivisor = rtZero ? 32'd1 : E_ReadData_rt;
    quotU    = E_ReadData_rs / uDivisor;
    remU     = E_ReadData_rs % uDivisor;
    hiTmp_d  = 32'd0;
    loTmp_d  = 32'd0;
    case (E_CU_MDU_op)
      OP_MULT:  begin hiTmp_d = prodS[63:32]; loTmp_d = prodS[31:0]; end
      OP_MULTU: begin hiTmp_d = prodU[63:32]; loTmp_d = prodU[31:0]; end
      OP_DIV:   begin hiTmp_d = remS;         loTmp_d = quotS;       end
      OP_DIVU:  begin hiTmp_d = remU;         loTmp_d = quotU;       end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      hiTmp_q    <= 32'd0;
      loTmp_q    <= 32'd0;
      commitEn_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q    <= isMult ? MULT : DIV;
            cnt_q      <= isMult ? 4'd5 : 4'd10;
            hiTmp_q    <= hiTmp_d;
            loTmp_q    <= loTmp_d;
            commitEn_q <= !(isDiv && rtZero);
            busy_q     <= 1'b1;
          end else if (E_CU_MDU_op == OP_MTHI) begin
            hi_q <= E_ReadData_rs;
          end else if (E_CU_MDU_op == OP_MTLO) begin
            lo_q <= E_ReadData_rs;
          end
        end
        default: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (commitEn_q) begin
              hi_q <= hiTmp_q;
              lo_q <= loTmp_q;
            end
          end
        end
      endcase
    end
  end

  assign MDU_busy  = busy_q;
  assign MDU_stall = (E_CU_MDU_op >= 4'd1) && (E_CU_MDU_op <= 4'd8) && (busy_q || E_CU_MDU_start);
  assign MDU_out   = (E_CU_MDU_op == OP_MFHI) ? hi_q :
                     (E_CU_MDU_op == OP_MFLO) ? lo_q : 32'd0;

`ifdef MDU_DIVZERO_FLAG_EN
  logic divzero_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      divzero_q <= 1'b0;
    else if (launch && isDiv && rtZero)
      divzero_q <= 1'b1;
  end

  assign MDU_divzero = divzero_q;
`else
  assign MDU_divzero = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against a 64-bit arithmetic model of HI/LO.
module tb_mdu_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  E_CU_MDU_op;
  logic        E_CU_MDU_start;
  logic [31:0] E_ReadData_rs;
  logic [31:0] E_ReadData_rt;
  logic        MDU_busy;
  logic        MDU_stall;
  logic [31:0] MDU_out;
  logic        MDU_divzero;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;
  logic        modelDz = 1'b0;

`ifdef MDU_DIVZERO_FLAG_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  mdu_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .E_CU_MDU_op    (E_CU_MDU_op),
    .E_CU_MDU_start (E_CU_MDU_start),
    .E_ReadData_rs  (E_ReadData_rs),
    .E_ReadData_rt  (E_ReadData_rt),
    .MDU_busy       (MDU_busy),
    .MDU_stall      (MDU_stall),
    .MDU_out        (MDU_out),
    .MDU_divzero    (MDU_divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural effect of a launched op, from plain 64-bit arithmetic.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y, r, q;
    logic [63:0] p;
    if (op == 4'd1 || op == 4'd3) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    if (op == 4'd1 || op == 4'd2) begin
      p = 64'(x * y);
      modelHi = p[63:32];
      modelLo = p[31:0];
    end else if (b == 32'd0) begin
      modelDz = DZ_EN;
    end else begin
      q = x / y;
      r = x % y;
      modelLo = q[31:0];
      modelHi = r[31:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    E_CU_MDU_op = 4'd5;
    #1 hi = MDU_out;
    E_CU_MDU_op = 4'd6;
    #1 lo = MDU_out;
    E_CU_MDU_op = 4'd0;
  endtask

  // Launches an op and counts the cycles busy stays high (bounded).
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busyCycles);
    E_CU_MDU_op = op;
    E_ReadData_rs = a;
    E_ReadData_rt = b;
    E_CU_MDU_start = 1'b1;
    step();
    E_CU_MDU_start = 1'b0;
    E_CU_MDU_op = 4'd0;
    modelOp(op, a, b);
    busyCycles = 0;
    while (MDU_busy && busyCycles < 40) begin
      busyCycles++;
      step();
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b0;
    E_CU_MDU_op = 4'd0;
    E_CU_MDU_start = 1'b0;
    E_ReadData_rs = 32'd0;
    E_ReadData_rt = 32'd0;
    step();
    step();
    checks++;
    if (MDU_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", MDU_busy); end
    checks++;
    if (MDU_divzero !== 1'b0) begin errors++; $display("[TB] FAIL reset_divzero got %0b want 0", MDU_divzero); end
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
    checks++;
    if (MDU_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %0b want 0", MDU_stall); end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int n;
    runOp(4'd1, 32'hFFFF_FFFE, 32'd3, n);
    checks++;
    if (n !== 5) begin errors++; $display("[TB] FAIL mult_latency got %0d want 5", n); end
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("[TB] FAIL mult_result got %h/%h want ffffffff/fffffffa", hi, lo);
    end
    checks++;
    if (hi !== modelHi || lo !== modelLo) begin
      errors++; $display("[TB] FAIL mult_model got %h/%h want %h/%h", hi, lo, modelHi, modelLo);
    end
  endtask

  task automatic test_divu_ignore();
    logic [31:0] hi, lo;
    int n;
    E_CU_MDU_op = 4'd4;
    E_ReadData_rs = 32'd7;
    E_ReadData_rt = 32'd2;
    E_CU_MDU_start = 1'b1;
    step();
    E_CU_MDU_start = 1'b0;
    E_CU_MDU_op = 4'd0;
    modelOp(4'd4, 32'd7, 32'd2);
    n = 0;
    while (MDU_busy && n < 40) begin
      n++;
      if (n == 4) begin
        E_CU_MDU_op = 4'd2;
        E_ReadData_rs = 32'd100;
        E_ReadData_rt = 32'd9;
        E_CU_MDU_start = 1'b1;
        #1;
        checks++;
        if (MDU_stall !== 1'b1) begin errors++; $display("[TB] FAIL busy_stall got %0b want 1", MDU_stall); end
      end
      step();
      E_CU_MDU_start = 1'b0;
      E_CU_MDU_op = 4'd0;
    end
    checks++;
    if (n !== 10) begin errors++; $display("[TB] FAIL divu_latency got %0d want 10", n); end
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++; $display("[TB] FAIL divu_result got %h/%h want 1/3", hi, lo);
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] hi, lo;
    int n;
    runOp(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("[TB] FAIL div_neg got %h/%h want ffffffff/fffffffd", hi, lo);
    end
    runOp(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("[TB] FAIL div_overflow got %h/%h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_mthi();
    logic [31:0] hi, lo;
    int n;
    E_CU_MDU_op = 4'd1;
    E_ReadData_rs = 32'd6;
    E_ReadData_rt = 32'd7;
    E_CU_MDU_start = 1'b1;
    step();
    E_CU_MDU_start = 1'b0;
    modelOp(4'd1, 32'd6, 32'd7);
    E_CU_MDU_op = 4'd7;
    E_ReadData_rs = 32'h1234;
    step();
    E_CU_MDU_op = 4'd0;
    n = 0;
    while (MDU_busy && n < 40) begin n++; step(); end
    readHiLo(hi, lo);
    checks++;
    if (hi !== modelHi || lo !== modelLo) begin
      errors++; $display("[TB] FAIL mthi_busy got %h/%h want %h/%h", hi, lo, modelHi, modelLo);
    end
    E_CU_MDU_op = 4'd7;
    E_ReadData_rs = 32'h1234;
    step();
    modelHi = 32'h1234;
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'h1234) begin errors++; $display("[TB] FAIL mthi_idle got %h want 00001234", hi); end
  endtask

  task automatic test_divzero();
    logic [31:0] hi, lo;
    int n;
    E_CU_MDU_op = 4'd8;
    E_ReadData_rs = 32'h55;
    step();
    modelLo = 32'h55;
    runOp(4'd3, 32'd99, 32'd0, n);
    checks++;
    if (n !== 10) begin errors++; $display("[TB] FAIL divzero_latency got %0d want 10", n); end
    readHiLo(hi, lo);
    checks++;
    if (lo !== 32'h55 || hi !== modelHi) begin
      errors++; $display("[TB] FAIL divzero_hilo got %h/%h want %h/00000055", hi, lo, modelHi);
    end
    checks++;
    if (MDU_divzero !== DZ_EN) begin errors++; $display("[TB] FAIL divzero_flag got %0b want %0b", MDU_divzero, DZ_EN); end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, a, b;
    logic [3:0] op;
    int n, want;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) begin
        E_CU_MDU_op = 4'($urandom_range(7, 8));
        E_ReadData_rs = $urandom;
        if (E_CU_MDU_op == 4'd7) modelHi = E_ReadData_rs; else modelLo = E_ReadData_rs;
        step();
      end
      E_CU_MDU_op = 4'($urandom_range(9, 15));
      E_CU_MDU_start = 1'b1;
      step();
      E_CU_MDU_start = 1'b0;
      checks++;
      if (MDU_busy !== 1'b0) begin errors++; $display("[TB] FAIL bad_op_start got busy %0b want 0", MDU_busy); end
      want = (op <= 4'd2) ? 5 : 10;
      runOp(op, a, b, n);
      checks++;
      if (n !== want) begin errors++; $display("[TB] FAIL rand_latency op %0d got %0d want %0d", op, n, want); end
      readHiLo(hi, lo);
      checks++;
      if (hi !== modelHi || lo !== modelLo) begin
        errors++;
        $display("[TB] FAIL rand_result op %0d a %h b %h got %h/%h want %h/%h", op, a, b, hi, lo, modelHi, modelLo);
      end
      checks++;
      if (MDU_divzero !== modelDz) begin errors++; $display("[TB] FAIL rand_divzero got %0b want %0b", MDU_divzero, modelDz); end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] hi, lo;
    E_CU_MDU_op = 4'd1;
    E_ReadData_rs = 32'd1000;
    E_ReadData_rt = 32'd1000;
    E_CU_MDU_start = 1'b1;
    step();
    E_CU_MDU_start = 1'b0;
    E_CU_MDU_op = 4'd0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (MDU_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b want 0", MDU_busy); end
    modelHi = 32'd0;
    modelLo = 32'd0;
    modelDz = 1'b0;
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("[TB] FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step();
    readHiLo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || MDU_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_nocommit got %h/%h busy %0b want 0/0 busy 0", hi, lo, MDU_busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_ignore();
    test_div_signed();
    test_mthi();
    test_divzero();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
